// File: rtl/div_pkg.sv
// Shared encodings and default widths for the divider scheduler.
package div_pkg;

    localparam int unsigned DEF_DEVIDENT_LENGTH = 6;
    localparam int unsigned DEF_DIVISOR_LENGTH  = 3;
    localparam int unsigned ID_WIDTH            = 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        CALC = ST_CALC,
        DONE = ST_DONE
    } state_t;

endpackage

// File: rtl/div_scheduler_if.sv
// Request and result handshake bundle between two requesters, the consumer and the scheduler.
interface div_scheduler_if
    import div_pkg::*;
#(
    parameter int unsigned DEVIDENT_LENGTH = DEF_DEVIDENT_LENGTH,
    parameter int unsigned DIVISOR_LENGTH  = DEF_DIVISOR_LENGTH
);
    logic                       Req0_Valid;
    logic                       Req0_Ready;
    logic [DEVIDENT_LENGTH-1:0] Req0_OperA;
    logic [DIVISOR_LENGTH-1:0]  Req0_OperD;
    logic                       Req1_Valid;
    logic                       Req1_Ready;
    logic [DEVIDENT_LENGTH-1:0] Req1_OperA;
    logic [DIVISOR_LENGTH-1:0]  Req1_OperD;
    logic                       Res_Valid;
    logic                       Res_Ready;
    logic [ID_WIDTH-1:0]        Res_Id;
    logic [DEVIDENT_LENGTH-1:0] Quotient;
    logic [DIVISOR_LENGTH-1:0]  Remainder;
    logic                       DivByZero;
    logic                       Busy;

    modport master (
        output Req0_Valid, Req0_OperA, Req0_OperD,
        output Req1_Valid, Req1_OperA, Req1_OperD,
        output Res_Ready,
        input  Req0_Ready, Req1_Ready,
        input  Res_Valid, Res_Id, Quotient, Remainder, DivByZero, Busy
    );

    modport slave (
        input  Req0_Valid, Req0_OperA, Req0_OperD,
        input  Req1_Valid, Req1_OperA, Req1_OperD,
        input  Res_Ready,
        output Req0_Ready, Req1_Ready,
        output Res_Valid, Res_Id, Quotient, Remainder, DivByZero, Busy
    );

endinterface

// File: rtl/array_divider.sv
// Combinational restoring array divider; paths through it are multicycle.
module array_divider #(
    parameter int unsigned DEVIDENT_LENGTH = 6,
    parameter int unsigned DIVISOR_LENGTH  = 3
) (
    input  logic [DEVIDENT_LENGTH-1:0] dividend,
    input  logic [DIVISOR_LENGTH-1:0]  divisor,
    output logic [DEVIDENT_LENGTH-1:0] quotient,
    output logic [DIVISOR_LENGTH-1:0]  remainder
);
    logic [DIVISOR_LENGTH:0] rem;

    // One shift/compare/subtract row per dividend bit, MSB first
    always_comb begin
        rem      = '0;
        quotient = '0;
        for (int i = DEVIDENT_LENGTH - 1; i >= 0; i--) begin
            rem = {rem[DIVISOR_LENGTH-1:0], dividend[i]};
            if (rem >= {1'b0, divisor}) begin
                rem         = rem - {1'b0, divisor};
                quotient[i] = 1'b1;
            end
        end
        remainder = rem[DIVISOR_LENGTH-1:0];
    end

endmodule

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter; the pointer moves away from whoever was just accepted.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] grant
);
    // ptr_q set means requester 1 wins a tie
    logic ptr_q;

    // Grant the lone requester, or break a tie with the pointer
    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = ptr_q ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

    // Flip priority to the other requester after every accept
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q <= 1'b0;
        end else if (accept) begin
            ptr_q <= grant[0];
        end
    end

endmodule

// File: rtl/div_scheduler.sv
// Shares one array divider between two requesters and returns results over valid/ready.
module div_scheduler
    import div_pkg::*;
#(
    parameter int unsigned DEVIDENT_LENGTH = DEF_DEVIDENT_LENGTH,
    parameter int unsigned DIVISOR_LENGTH  = DEF_DIVISOR_LENGTH,
    parameter int unsigned SETTLE_CYCLES   = 2
) (
    input logic            CLK,
    input logic            RST_n,
    div_scheduler_if.slave bus
);
    localparam int unsigned CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    state_t                     state_q, state_d;
    logic [CNT_W-1:0]           cnt_q;
    logic [DEVIDENT_LENGTH-1:0] opa_q, quot_q, arr_quot, acc_a;
    logic [DIVISOR_LENGTH-1:0]  opd_q, rem_q, arr_rem, acc_d;
    logic [ID_WIDTH-1:0]        id_q, acc_id;
    logic                       dz_q;
    logic [1:0]                 req, grant;
    logic                       idle, accept;

    assign idle   = (state_q == IDLE);
    assign req    = {bus.Req1_Valid, bus.Req0_Valid};

    rr_arbiter2 u_arb (
        .clk    (CLK),
        .rst_n  (RST_n),
        .req    (req),
        .accept (accept),
        .grant  (grant)
    );

    assign bus.Req0_Ready = RST_n & idle & grant[0];
    assign bus.Req1_Ready = RST_n & idle & grant[1];
    assign accept = (bus.Req0_Valid & bus.Req0_Ready) | (bus.Req1_Valid & bus.Req1_Ready);
    assign acc_a  = grant[1] ? bus.Req1_OperA : bus.Req0_OperA;
    assign acc_d  = grant[1] ? bus.Req1_OperD : bus.Req0_OperD;
    assign acc_id = grant[1];

    array_divider #(
        .DEVIDENT_LENGTH (DEVIDENT_LENGTH),
        .DIVISOR_LENGTH  (DIVISOR_LENGTH)
    ) u_div (
        .dividend  (opa_q),
        .divisor   (opd_q),
        .quotient  (arr_quot),
        .remainder (arr_rem)
    );

    // State register
    always_ff @(posedge CLK) begin
        if (!RST_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state; the latched divisor is inspected in the first CALC cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = CALC;
            CALC:    if ((opd_q == '0) || (cnt_q == '0)) state_d = DONE;
            DONE:    if (bus.Res_Ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Operand capture, settle counter and result registers
    always_ff @(posedge CLK) begin
        if (!RST_n) begin
            opa_q  <= '0;
            opd_q  <= '0;
            id_q   <= '0;
            cnt_q  <= '0;
            quot_q <= '0;
            rem_q  <= '0;
            dz_q   <= 1'b0;
        end else if (idle && accept) begin
            opa_q <= acc_a;
            opd_q <= acc_d;
            id_q  <= acc_id;
            cnt_q <= CNT_W'(SETTLE_CYCLES - 1);
        end else if (state_q == CALC) begin
            if (opd_q == '0) begin
                // Array output is ignored for a zero divisor
                quot_q <= '1;
                rem_q  <= '0;
                dz_q   <= 1'b1;
            end else if (cnt_q == '0) begin
                quot_q <= arr_quot;
                rem_q  <= arr_rem;
                dz_q   <= 1'b0;
            end else begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
        end
    end

    assign bus.Res_Valid = (state_q == DONE);
    assign bus.Busy      = ~idle;
    assign bus.Res_Id    = id_q;
    assign bus.Quotient  = quot_q;
    assign bus.Remainder = rem_q;
    assign bus.DivByZero = dz_q;

endmodule

// File: tb/tb_div_scheduler.sv
// Directed bench for div_scheduler: vector table, arbitration, stall, reset and sweep.
module tb_div_scheduler;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    div_scheduler_if #(.DEVIDENT_LENGTH(6), .DIVISOR_LENGTH(3)) bus ();
    div_scheduler_if #(.DEVIDENT_LENGTH(6), .DIVISOR_LENGTH(3)) bus1 ();

    div_scheduler #(.DEVIDENT_LENGTH(6), .DIVISOR_LENGTH(3), .SETTLE_CYCLES(2)) dut (
        .CLK   (clk),
        .RST_n (rst_n),
        .bus   (bus)
    );

    div_scheduler #(.DEVIDENT_LENGTH(6), .DIVISOR_LENGTH(3), .SETTLE_CYCLES(1)) dut_s1 (
        .CLK   (clk),
        .RST_n (rst_n),
        .bus   (bus1)
    );

    typedef struct {
        bit         id;
        logic [5:0] a;
        logic [2:0] d;
        int         lat;
        logic [5:0] q;
        logic [2:0] r;
        bit         dz;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_inputs();
        bus.Req0_Valid = 1'b0; bus.Req0_OperA = '0; bus.Req0_OperD = '0;
        bus.Req1_Valid = 1'b0; bus.Req1_OperA = '0; bus.Req1_OperD = '0;
        bus.Res_Ready  = 1'b0;
        bus1.Req0_Valid = 1'b0; bus1.Req0_OperA = '0; bus1.Req0_OperD = '0;
        bus1.Req1_Valid = 1'b0; bus1.Req1_OperA = '0; bus1.Req1_OperD = '0;
        bus1.Res_Ready  = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (bus.Busy && n < 20) begin
            tick();
            n++;
        end
        check({tag, " back to idle"}, bus.Busy, 0);
    endtask

    // One operation on the default build with Res_Ready held high throughout
    task automatic run_op(input bit id, input logic [5:0] a, input logic [2:0] d, input int lat,
                          input logic [5:0] eq, input logic [2:0] er, input bit edz,
                          input string tag);
        int n;
        bus.Res_Ready = 1'b1;
        if (id) begin
            bus.Req1_Valid = 1'b1; bus.Req1_OperA = a; bus.Req1_OperD = d;
        end else begin
            bus.Req0_Valid = 1'b1; bus.Req0_OperA = a; bus.Req0_OperD = d;
        end
        #1;
        check({tag, " ready"}, id ? bus.Req1_Ready : bus.Req0_Ready, 1);
        check({tag, " other ready"}, id ? bus.Req0_Ready : bus.Req1_Ready, 0);
        tick();
        // Operands scrambled after acceptance must not matter
        bus.Req0_Valid = 1'b0; bus.Req0_OperA = ~a; bus.Req0_OperD = ~d;
        bus.Req1_Valid = 1'b0; bus.Req1_OperA = ~a; bus.Req1_OperD = ~d;
        n = 0;
        while (!bus.Res_Valid && n < 10) begin
            tick();
            n++;
        end
        check({tag, " latency"}, n, lat);
        check({tag, " quotient"}, bus.Quotient, eq);
        check({tag, " remainder"}, bus.Remainder, er);
        check({tag, " divbyzero"}, bus.DivByZero, edz);
        check({tag, " id"}, bus.Res_Id, id);
        check({tag, " busy"}, bus.Busy, 1);
        tick();
        check({tag, " valid drop"}, bus.Res_Valid, 0);
        check({tag, " idle"}, bus.Busy, 0);
    endtask

    // One operation on the SETTLE_CYCLES=1 build
    task automatic run_op1(input logic [5:0] a, input logic [2:0] d,
                           input logic [5:0] eq, input logic [2:0] er, input bit edz,
                           input string tag);
        int n;
        bus1.Res_Ready  = 1'b1;
        bus1.Req0_Valid = 1'b1; bus1.Req0_OperA = a; bus1.Req0_OperD = d;
        #1;
        check({tag, " ready"}, bus1.Req0_Ready, 1);
        tick();
        bus1.Req0_Valid = 1'b0;
        n = 0;
        while (!bus1.Res_Valid && n < 10) begin
            tick();
            n++;
        end
        check({tag, " latency"}, n, 1);
        check({tag, " quotient"}, bus1.Quotient, eq);
        check({tag, " remainder"}, bus1.Remainder, er);
        check({tag, " divbyzero"}, bus1.DivByZero, edz);
        tick();
        check({tag, " idle"}, bus1.Busy, 0);
    endtask

    initial begin
        int         ids [4];
        int         at  [4];
        int         n_acc;
        int         n;
        logic [5:0] sa;
        logic [2:0] sd;

        vecs[0] = '{id: 1'b0, a: 6'd45, d: 3'd6, lat: 2, q: 6'd7,  r: 3'd3, dz: 1'b0};
        vecs[1] = '{id: 1'b1, a: 6'd62, d: 3'd5, lat: 2, q: 6'd12, r: 3'd2, dz: 1'b0};
        vecs[2] = '{id: 1'b0, a: 6'd63, d: 3'd1, lat: 2, q: 6'd63, r: 3'd0, dz: 1'b0};
        vecs[3] = '{id: 1'b1, a: 6'd0,  d: 3'd5, lat: 2, q: 6'd0,  r: 3'd0, dz: 1'b0};
        vecs[4] = '{id: 1'b0, a: 6'd13, d: 3'd4, lat: 2, q: 6'd3,  r: 3'd1, dz: 1'b0};
        vecs[5] = '{id: 1'b0, a: 6'd5,  d: 3'd7, lat: 2, q: 6'd0,  r: 3'd5, dz: 1'b0};
        vecs[6] = '{id: 1'b1, a: 6'd20, d: 3'd0, lat: 1, q: 6'h3F, r: 3'd0, dz: 1'b1};

        // Reset state
        rst_n = 1'b0;
        clear_inputs();
        tick();
        tick();
        check("reset busy", bus.Busy, 0);
        check("reset res_valid", bus.Res_Valid, 0);
        check("reset quotient", bus.Quotient, 0);
        check("reset remainder", bus.Remainder, 0);
        check("reset divbyzero", bus.DivByZero, 0);
        check("reset res_id", bus.Res_Id, 0);
        bus.Req0_Valid = 1'b1;
        #1;
        check("ready forced low in reset", bus.Req0_Ready, 0);
        bus.Req0_Valid = 1'b0;
        rst_n = 1'b1;
        tick();

        // Both requesters valid continuously: alternating grants, 4 cycles apart
        bus.Res_Ready  = 1'b1;
        bus.Req0_Valid = 1'b1; bus.Req0_OperA = 6'd45; bus.Req0_OperD = 3'd6;
        bus.Req1_Valid = 1'b1; bus.Req1_OperA = 6'd20; bus.Req1_OperD = 3'd3;
        #1;
        n_acc = 0;
        for (int c = 0; c < 40 && n_acc < 4; c++) begin
            if (bus.Req0_Ready && bus.Req1_Ready) begin
                check("rr single grant", 2, 1);
            end
            if (bus.Req0_Ready) begin
                ids[n_acc] = 0; at[n_acc] = c; n_acc++;
            end else if (bus.Req1_Ready) begin
                ids[n_acc] = 1; at[n_acc] = c; n_acc++;
            end
            tick();
        end
        bus.Req0_Valid = 1'b0;
        bus.Req1_Valid = 1'b0;
        check("rr accept count", n_acc, 4);
        for (int k = 0; k < n_acc; k++) begin
            check($sformatf("rr grant %0d", k), ids[k], k % 2);
            if (k > 0) check($sformatf("rr spacing %0d", k), at[k] - at[k-1], 4);
        end
        wait_idle("rr");

        // 63/7 with the consumer stalled for 5 cycles
        bus.Res_Ready  = 1'b0;
        bus.Req0_Valid = 1'b1; bus.Req0_OperA = 6'd63; bus.Req0_OperD = 3'd7;
        #1;
        tick();
        bus.Req0_Valid = 1'b0;
        n = 0;
        while (!bus.Res_Valid && n < 10) begin
            tick();
            n++;
        end
        check("stall latency", n, 2);
        for (int c = 0; c < 5; c++) begin
            bus.Req0_Valid = 1'b1;
            bus.Req1_Valid = 1'b1;
            #1;
            check("stall res_valid", bus.Res_Valid, 1);
            check("stall quotient", bus.Quotient, 9);
            check("stall remainder", bus.Remainder, 0);
            check("stall req0_ready", bus.Req0_Ready, 0);
            check("stall req1_ready", bus.Req1_Ready, 0);
            tick();
        end
        bus.Req0_Valid = 1'b0;
        bus.Req1_Valid = 1'b0;
        bus.Res_Ready  = 1'b1;
        tick();
        check("stall release idle", bus.Busy, 0);
        check("stall release valid", bus.Res_Valid, 0);
        check("stall quotient held", bus.Quotient, 9);

        // Directed vector table
        foreach (vecs[i]) begin
            run_op(vecs[i].id, vecs[i].a, vecs[i].d, vecs[i].lat, vecs[i].q, vecs[i].r,
                   vecs[i].dz, $sformatf("vec%0d", i));
        end

        // Reset pulsed during CALC; pointer currently favours requester 0 again after reset
        bus.Res_Ready  = 1'b1;
        bus.Req0_Valid = 1'b1; bus.Req0_OperA = 6'd45; bus.Req0_OperD = 3'd6;
        #1;
        tick();
        bus.Req0_Valid = 1'b0;
        tick();
        check("pre-reset busy", bus.Busy, 1);
        rst_n = 1'b0;
        tick();
        bus.Req0_Valid = 1'b1;
        bus.Req1_Valid = 1'b1;
        #1;
        check("midreset busy", bus.Busy, 0);
        check("midreset res_valid", bus.Res_Valid, 0);
        check("midreset quotient", bus.Quotient, 0);
        check("midreset remainder", bus.Remainder, 0);
        check("midreset divbyzero", bus.DivByZero, 0);
        check("midreset res_id", bus.Res_Id, 0);
        check("midreset ready forced", bus.Req0_Ready, 0);
        rst_n = 1'b1;
        #1;
        check("post-reset grant req0", bus.Req0_Ready, 1);
        check("post-reset no req1", bus.Req1_Ready, 0);
        tick();
        bus.Req0_Valid = 1'b0;
        bus.Req1_Valid = 1'b0;
        wait_idle("post-reset");

        // Full sweep of dividends against every nonzero divisor
        for (int a = 0; a < 64; a++) begin
            for (int d = 1; d < 8; d++) begin
                sa = 6'(a);
                sd = 3'(d);
                run_op(sa[0], sa, sd, 2, 6'(a / d), 3'(a % d), 1'b0,
                       $sformatf("sweep %0d/%0d", a, d));
            end
        end

        // Single-cycle settle build
        run_op1(6'd45, 3'd6, 6'd7, 3'd3, 1'b0, "s1 45/6");
        run_op1(6'd20, 3'd0, 6'h3F, 3'd0, 1'b1, "s1 20/0");
        run_op1(6'd63, 3'd7, 6'd9, 3'd0, 1'b0, "s1 63/7");
        run_op1(6'd50, 3'd3, 6'd16, 3'd2, 1'b0, "s1 50/3");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
